// File: rtl/cache_pkg.sv
// cache_pkg: shared definitions for the data_cache block.
//   state_t           - controller FSM encoding (IDLE, MEM_RD, MEM_WR, RESP)
//   DEF_SETS          - default number of direct-mapped lines
//   index_w / tag_w   - address field widths derived from the line count
//   DW_*              - DataWidth access-width codes
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MEM_RD = 2'd1,
    MEM_WR = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam int DEF_SETS = 8;

  localparam logic [2:0] DW_WORD  = 3'b000;
  localparam logic [2:0] DW_HALF  = 3'b001;
  localparam logic [2:0] DW_BYTE  = 3'b010;
  localparam logic [2:0] DW_HALFU = 3'b101;
  localparam logic [2:0] DW_BYTEU = 3'b110;

  // One 32-bit word per line, so the index sits directly above the byte offset.
  function automatic int index_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int sets);
    return 30 - $clog2(sets);
  endfunction

endpackage

// File: rtl/cache_store.sv
// cache_store: tag/valid/data arrays for the direct-mapped data cache.
//   clk, rst                     - clock, asynchronous active-low reset (valid bits only)
//   rd_index -> rd_valid/tag/data - combinational read port
//   wr_en, wr_index/tag/data     - write port; writing a line also sets its valid bit
//   inv_en, inv_index            - clears one valid bit
module cache_store
  import cache_pkg::*;
#(
  parameter int SETS = DEF_SETS,
  parameter int IW   = index_w(SETS),
  parameter int TW   = tag_w(SETS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] rd_index,
  output logic          rd_valid,
  output logic [TW-1:0] rd_tag,
  output logic [31:0]   rd_data,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_index,
  input  logic [TW-1:0] wr_tag,
  input  logic [31:0]   wr_data,
  input  logic          inv_en,
  input  logic [IW-1:0] inv_index
);

  logic [SETS-1:0] valid_q;
  logic [TW-1:0]   tag_q  [SETS];
  logic [31:0]     data_q [SETS];

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else begin
      if (wr_en)  valid_q[wr_index]  <= 1'b1;
      if (inv_en) valid_q[inv_index] <= 1'b0;
    end
  end

  // Tag and data contents are meaningless until valid is set, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_data;
    end
  end

endmodule

// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-through, no-write-allocate data cache.
//   clk, rst            - clock, asynchronous active-low reset
//   cacheEn             - access may use / fill the cache
//   MemRead, MemWrite   - load / store request (both high = store)
//   DataWidth, A, WD    - access width code, byte address, store data
//   RD, Stall           - load data; core holds request while Stall is high
//   mem_*               - backing memory port
//   dbg_state           - current controller state (state_t encoding)
//
// Memory handshake: mem_req is the valid; while it is high, mem_we, mem_addr,
// mem_wdata and mem_width are stable. The transfer completes in the cycle
// mem_ready is high while mem_req is high; mem_ready is ignored otherwise.
module data_cache
  import cache_pkg::*;
#(
  parameter int SETS = DEF_SETS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cacheEn,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  DataWidth,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        Stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_width,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [1:0]  dbg_state
);

  localparam int IW = index_w(SETS);
  localparam int TW = tag_w(SETS);

  state_t        state;
  logic [31:0]   resp_q;

  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic          line_valid;
  logic [TW-1:0] line_tag;
  logic [31:0]   line_data;
  logic          match;
  logic          hit;
  logic          is_wr;
  logic          is_rd;
  logic          fill_en;
  logic          upd_en;
  logic          inv_en;

  assign idx   = A[IW+1:2];
  assign tag   = A[31:IW+2];
  assign is_wr = MemWrite;
  assign is_rd = MemRead & ~MemWrite;

  // match ignores cacheEn so an uncached store can still find a stale line.
  assign match = line_valid & (line_tag == tag);
  assign hit   = cacheEn & match;

  assign fill_en = (state == MEM_RD) & mem_ready & cacheEn;
  assign upd_en  = (state == MEM_WR) & mem_ready & hit;
  // Sub-word (uncached) store: the cached word no longer matches memory.
  assign inv_en  = (state == MEM_WR) & mem_ready & ~cacheEn & match;

  cache_store #(.SETS(SETS), .IW(IW), .TW(TW)) u_store (
    .clk       (clk),
    .rst       (rst),
    .rd_index  (idx),
    .rd_valid  (line_valid),
    .rd_tag    (line_tag),
    .rd_data   (line_data),
    .wr_en     (fill_en | upd_en),
    .wr_index  (idx),
    .wr_tag    (tag),
    .wr_data   (fill_en ? mem_rdata : WD),
    .inv_en    (inv_en),
    .inv_index (idx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      resp_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (is_wr)               state <= MEM_WR;
          else if (is_rd && !hit)  state <= MEM_RD;
        end
        MEM_RD: begin
          if (mem_ready) begin
            resp_q <= mem_rdata;
            state  <= RESP;
          end
        end
        MEM_WR: begin
          if (mem_ready) begin
            resp_q <= '0;
            state  <= RESP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Request fields pass straight through: the core holds them while stalled.
  assign mem_req   = (state == MEM_RD) | (state == MEM_WR);
  assign mem_we    = (state == MEM_WR);
  assign mem_addr  = A;
  assign mem_wdata = WD;
  assign mem_width = DataWidth;
  assign dbg_state = state;

  always_comb begin
    Stall = 1'b0;
    RD    = '0;
    case (state)
      IDLE: begin
        Stall = is_wr | (is_rd & ~hit);
        if (is_rd && hit) RD = line_data;
      end
      MEM_RD, MEM_WR: Stall = 1'b1;
      default: begin
        if (MemRead || MemWrite) RD = resp_q;
      end
    endcase
  end

endmodule

// File: tb/tb_data_cache.sv
module tb_data_cache;
  import cache_pkg::*;

  localparam int MEM_DLY = 3;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  always #5 clk = ~clk;

  logic        cacheEn = 1'b0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [2:0]  DataWidth = 3'b000;
  logic [31:0] A = '0;
  logic [31:0] WD = '0;
  logic [31:0] RD;
  logic        Stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_width;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic [1:0]  dbg_state;

  data_cache #(.SETS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cacheEn   (cacheEn),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .DataWidth (DataWidth),
    .A         (A),
    .WD        (WD),
    .RD        (RD),
    .Stall     (Stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_width (mem_width),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] rd;
    bit          mem;
    bit          we;
    logic [2:0]  width;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] mem_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- memory model: ready on the MEM_DLY-th request cycle ----------------
  int mcnt = 0;
  always @(negedge clk) begin
    if (mem_req) begin
      mcnt++;
      mem_ready = (mcnt == MEM_DLY);
      mem_rdata = mem_data;
    end else begin
      mcnt = 0;
      mem_ready = 1'b0;
    end
  end

  // ---------------- monitor ----------------
  int   cyc = 0;
  bit   seen = 1'b0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst || !(MemRead || MemWrite)) begin
      cyc = 0;
      seen = 1'b0;
    end else begin
      cyc++;
      if (mem_req) begin
        seen = 1'b1;
        if (exp_q.size() > 0) begin
          chk("mem_we", {31'b0, mem_we}, {31'b0, exp_q[0].we});
          chk("mem_addr", mem_addr, exp_q[0].addr);
          chk("mem_width", {29'b0, mem_width}, {29'b0, exp_q[0].width});
          if (exp_q[0].we) chk("mem_wdata", mem_wdata, exp_q[0].wdata);
        end
      end
      if (!Stall) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_response: got RD %h expected no response", RD);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rd", RD, mon_e.rd);
          chk("mem_access", {31'b0, seen}, {31'b0, mon_e.mem});
          chk("latency", cyc, mon_e.lat);
        end
        cyc = 0;
        seen = 1'b0;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic access(input bit rd, input bit wr, input bit en, input logic [2:0] w,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] mdata, input logic [31:0] exp_rd, input bit exp_mem);
    exp_t e;
    bit   done;
    e.rd    = exp_rd;
    e.mem   = exp_mem;
    e.we    = wr;
    e.width = w;
    e.addr  = addr;
    e.wdata = wd;
    e.lat   = exp_mem ? (MEM_DLY + 2) : 1;
    @(posedge clk);
    #1;
    mem_data  = mdata;
    exp_q.push_back(e);
    MemRead   = rd;
    MemWrite  = wr;
    cacheEn   = en;
    DataWidth = w;
    A         = addr;
    WD        = wd;
    done      = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      if (!Stall) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: addr %h still stalled, expected completion", addr);
      exp_q.delete();
    end
    MemRead  = 1'b0;
    MemWrite = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", {30'b0, dbg_state}, 32'(IDLE));
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_stall", {31'b0, Stall}, 32'd0);
    chk("rst_rd", RD, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // load miss then hit
    access(1, 0, 1, DW_WORD, 32'h100, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 1);
    access(1, 0, 1, DW_WORD, 32'h100, 32'h0, 32'h0,        32'hDEADBEEF, 0);
    // cached store hits and updates line
    access(0, 1, 1, DW_WORD, 32'h100, 32'hCAFEF00D, 32'h0, 32'h0, 1);
    access(1, 0, 1, DW_WORD, 32'h100, 32'h0, 32'h0,        32'hCAFEF00D, 0);
    // conflicting index: 0x120 evicts 0x100
    access(1, 0, 1, DW_WORD, 32'h120, 32'h0, 32'h12345678, 32'h12345678, 1);
    access(1, 0, 1, DW_WORD, 32'h120, 32'h0, 32'h0,        32'h12345678, 0);
    access(1, 0, 1, DW_WORD, 32'h100, 32'h0, 32'hCAFEF00D, 32'hCAFEF00D, 1);
    // uncached byte store invalidates the line
    access(0, 1, 0, DW_BYTE, 32'h100, 32'h000000AB, 32'h0, 32'h0, 1);
    access(1, 0, 1, DW_WORD, 32'h100, 32'h0, 32'hCAFEF0AB, 32'hCAFEF0AB, 1);
    // byte-unsigned bypass load never fills
    access(1, 0, 0, DW_BYTEU, 32'h104, 32'h0, 32'h000000EE, 32'h000000EE, 1);
    access(1, 0, 0, DW_BYTEU, 32'h104, 32'h0, 32'h000000EE, 32'h000000EE, 1);
    // cached store miss does not allocate or disturb the resident line
    access(0, 1, 1, DW_WORD, 32'h140, 32'h00000055, 32'h0, 32'h0, 1);
    access(1, 0, 1, DW_WORD, 32'h100, 32'h0, 32'h0,        32'hCAFEF0AB, 0);
    // read+write together behaves as a store
    access(1, 1, 1, DW_WORD, 32'h100, 32'h11112222, 32'h0, 32'h0, 1);
    access(1, 0, 1, DW_WORD, 32'h100, 32'h0, 32'h0,        32'h11112222, 0);

    // reset in the middle of a read miss
    @(posedge clk);
    #1;
    mem_data  = 32'h12345678;
    MemRead   = 1'b1;
    cacheEn   = 1'b1;
    DataWidth = DW_WORD;
    A         = 32'h120;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req) break;
    end
    chk("abort_pre_req", {31'b0, mem_req}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("abort_mem_req", {31'b0, mem_req}, 32'd0);
    chk("abort_state", {30'b0, dbg_state}, 32'(IDLE));
    MemRead = 1'b0;
    #1;
    chk("abort_stall", {31'b0, Stall}, 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    access(1, 0, 1, DW_WORD, 32'h100, 32'h0, 32'h11112222, 32'h11112222, 1);
    access(1, 0, 1, DW_WORD, 32'h120, 32'h0, 32'h12345678, 32'h12345678, 1);

    repeat (2) @(posedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
